// File: rtl/poly_horner_mac_if.sv
// Handshake and status bundle of poly_horner_mac: sample stream in, coefficient
// load stream in, result stream out, plus FIFO/coefficient/overflow status.
interface poly_horner_mac_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] sample_i;
  logic                  sample_valid_i;
  logic                  sample_ready_o;
  logic [DATA_WIDTH-1:0] coeff_i;
  logic                  coeff_valid_i;
  logic                  coeff_ready_o;
  logic                  coeff_reload_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic                  fifo_full_o;
  logic                  fifo_empty_o;
  logic                  coeff_loaded_o;
  logic                  overflow_o;

  modport slave (
    input  sample_i, sample_valid_i, coeff_i, coeff_valid_i, coeff_reload_i, result_ready_i,
    output sample_ready_o, coeff_ready_o, result_o, result_valid_o,
           fifo_full_o, fifo_empty_o, coeff_loaded_o, overflow_o
  );

  modport master (
    output sample_i, sample_valid_i, coeff_i, coeff_valid_i, coeff_reload_i, result_ready_i,
    input  sample_ready_o, coeff_ready_o, result_o, result_valid_o,
           fifo_full_o, fifo_empty_o, coeff_loaded_o, overflow_o
  );
endinterface

// File: rtl/poly_horner_mac.sv
// Streaming Horner polynomial evaluator with sample FIFO and reloadable coefficient bank.
// Define POLY_ROUND_EN to round half up before the fixed-point shift (default: truncate).
module poly_horner_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N_TERMS    = 3,
  parameter int ADDR_LINES = 4
) (
  input logic              clk_i,
  input logic              rstn_i,
  poly_horner_mac_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int KI    = $clog2(N_TERMS);
  localparam int KW    = KI + 1;
  localparam int DEPTH = 2 ** ADDR_LINES;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] RND_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND     = RND_ONE <<< (FRAC_BITS - 1);
  localparam logic [ADDR_LINES:0]  PTR_ONE = {{ADDR_LINES{1'b0}}, 1'b1};
  localparam logic [KW-1:0]        K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]        K_ZERO  = {KW{1'b0}};
  localparam logic [KW-1:0]        K_LAST  = KW'(N_TERMS - 1);
  localparam logic [KW-1:0]        K_START = KW'(N_TERMS - 2);
  localparam logic [KI-1:0]        K_TOP   = KI'(N_TERMS - 1);

  typedef enum logic [1:0] {
    LOAD_COEF = 2'd0,
    IDLE      = 2'd1,
    COMPUTE   = 2'd2,
    OUTPUT    = 2'd3
  } state_t;

  state_t                 state_r, next_state_s;
  logic [ADDR_LINES:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
  logic [DW-1:0]          mem_r [DEPTH];
  logic [DW-1:0]          head_s;
  logic                   full_r, empty_r, full_nx_s, empty_nx_s, sample_ready_r;
  logic signed [DW-1:0]   coef_r [N_TERMS];
  logic signed [DW-1:0]   acc_r, x_r;
  logic [KW-1:0]          k_r;
  logic [KI-1:0]          kidx_s, widx_s;
  logic                   coeff_ready_r, coeff_loaded_r, result_valid_r, overflow_r, reload_pend_r;
  logic                   push_s, pop_s, coef_hs_s, res_hs_s, reload_s;
  logic signed [PW-1:0]   prod_s, shift_s, sum_s;
  logic [DW:0]            psat_s, ssat_s;

  // Clamp a double-width value into DW bits; MSB of the result flags saturation.
  function automatic logic [DW:0] sat_fn(input logic signed [PW-1:0] v);
    logic [DW:0] r;
    if (v > PW'(SAT_MAX)) begin
      r = {1'b1, SAT_MAX};
    end else if (v < PW'(SAT_MIN)) begin
      r = {1'b1, SAT_MIN};
    end else begin
      r = {1'b0, v[DW-1:0]};
    end
    return r;
  endfunction

  assign push_s    = bus.sample_valid_i && sample_ready_r && !full_r;
  assign coef_hs_s = bus.coeff_valid_i && coeff_ready_r;
  assign res_hs_s  = result_valid_r && bus.result_ready_i;
  assign reload_s  = bus.coeff_reload_i || reload_pend_r;
  assign head_s    = mem_r[rd_ptr_r[ADDR_LINES-1:0]];
  assign kidx_s    = k_r[KI-1:0];
  assign widx_s    = K_TOP - k_r[KI-1:0];

  // Next FIFO pointers and flags; flags are registered from these.
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    if (push_s) wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
    else        wr_ptr_nx_s = wr_ptr_r;
    if (pop_s)  rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
    else        rd_ptr_nx_s = rd_ptr_r;
    empty_nx_s = (wr_ptr_nx_s == rd_ptr_nx_s);
    full_nx_s  = (wr_ptr_nx_s[ADDR_LINES] != rd_ptr_nx_s[ADDR_LINES]) &&
                 (wr_ptr_nx_s[ADDR_LINES-1:0] == rd_ptr_nx_s[ADDR_LINES-1:0]);
  end

  // One Horner step: saturated (acc*x >> FRAC_BITS) + c[k], saturated again.
  always_comb begin
    prod_s = PW'(acc_r) * PW'(x_r);
`ifdef POLY_ROUND_EN
    shift_s = (prod_s + RND) >>> FRAC_BITS;
`else
    shift_s = prod_s >>> FRAC_BITS;
`endif
    psat_s = sat_fn(shift_s);
    sum_s  = PW'($signed(psat_s[DW-1:0])) + PW'(coef_r[kidx_s]);
    ssat_s = sat_fn(sum_s);
  end

  // Next-state decode; a pending reload in IDLE wins over a pop.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      LOAD_COEF: begin
        if (coef_hs_s && (k_r == K_LAST)) next_state_s = IDLE;
        else                              next_state_s = LOAD_COEF;
      end
      IDLE: begin
        if (reload_s) begin
          next_state_s = LOAD_COEF;
        end else if (!empty_r) begin
          pop_s        = 1'b1;
          next_state_s = COMPUTE;
        end else begin
          next_state_s = IDLE;
        end
      end
      COMPUTE: begin
        if (k_r == K_ZERO) next_state_s = OUTPUT;
        else               next_state_s = COMPUTE;
      end
      OUTPUT: begin
        if (res_hs_s) next_state_s = IDLE;
        else          next_state_s = OUTPUT;
      end
      default: next_state_s = LOAD_COEF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_r <= LOAD_COEF;
    else         state_r <= next_state_s;
  end

  // FIFO pointers, flags and registered ready.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r       <= {(ADDR_LINES+1){1'b0}};
      rd_ptr_r       <= {(ADDR_LINES+1){1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      sample_ready_r <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nx_s;
      rd_ptr_r       <= rd_ptr_nx_s;
      full_r         <= full_nx_s;
      empty_r        <= empty_nx_s;
      sample_ready_r <= !full_nx_s;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r[ADDR_LINES-1:0]] <= bus.sample_i;
  end

  // Coefficient bank, Horner accumulator, counter and status flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_TERMS; i++) coef_r[i] <= {DW{1'b0}};
      acc_r          <= {DW{1'b0}};
      x_r            <= {DW{1'b0}};
      k_r            <= K_ZERO;
      coeff_ready_r  <= 1'b0;
      coeff_loaded_r <= 1'b0;
      result_valid_r <= 1'b0;
      overflow_r     <= 1'b0;
      reload_pend_r  <= 1'b0;
    end else begin
      coeff_ready_r  <= (next_state_s == LOAD_COEF);
      result_valid_r <= (next_state_s == OUTPUT);
      case (state_r)
        LOAD_COEF: begin
          reload_pend_r <= 1'b0;
          if (coef_hs_s) begin
            coef_r[widx_s] <= bus.coeff_i;
            k_r            <= k_r + K_ONE;
            if (k_r == K_LAST) coeff_loaded_r <= 1'b1;
          end
        end
        IDLE: begin
          if (reload_s) begin
            coeff_loaded_r <= 1'b0;
            k_r            <= K_ZERO;
            reload_pend_r  <= 1'b0;
          end else if (pop_s) begin
            x_r   <= head_s;
            acc_r <= coef_r[N_TERMS-1];
            k_r   <= K_START;
          end
        end
        COMPUTE: begin
          acc_r <= ssat_s[DW-1:0];
          if (psat_s[DW] || ssat_s[DW]) overflow_r <= 1'b1;
          if (k_r != K_ZERO) k_r <= k_r - K_ONE;
          if (bus.coeff_reload_i) reload_pend_r <= 1'b1;
        end
        OUTPUT: begin
          if (bus.coeff_reload_i) reload_pend_r <= 1'b1;
        end
        default: reload_pend_r <= 1'b0;
      endcase
    end
  end

  assign bus.sample_ready_o = sample_ready_r;
  assign bus.coeff_ready_o  = coeff_ready_r;
  assign bus.result_o       = acc_r;
  assign bus.result_valid_o = result_valid_r;
  assign bus.fifo_full_o    = full_r;
  assign bus.fifo_empty_o   = empty_r;
  assign bus.coeff_loaded_o = coeff_loaded_r;
  assign bus.overflow_o     = overflow_r;
endmodule

// File: tb/tb_poly_horner_mac.sv
// Self-checking bench for poly_horner_mac: directed and random samples against a
// plain-arithmetic Horner reference model with saturation.
module tb_poly_horner_mac;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NT = 3;
  localparam int AL = 4;
  localparam longint MAXV = 64'sd32767;
  localparam longint MINV = -64'sd32768;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  longint cf [NT];
  bit   m_ovf = 1'b0;
  logic [15:0] q [$];

  always #5 clk = ~clk;

  poly_horner_mac_if #(.DATA_WIDTH(DW)) bus ();

  poly_horner_mac #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .N_TERMS(NT), .ADDR_LINES(AL)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference: p(x) by Horner with cf[0] the highest-order coefficient.
  function automatic longint model_eval(input logic [15:0] xin);
    longint x, acc, p, t;
    x   = longint'($signed(xin));
    acc = cf[0];
    for (int i = 1; i < NT; i++) begin
      p = acc * x;
`ifdef POLY_ROUND_EN
      p = p + (longint'(1) <<< (FB - 1));
`endif
      p = p >>> FB;
      t = clampv(p);
      if (t != p) m_ovf = 1'b1;
      p = t + cf[i];
      t = clampv(p);
      if (t != p) m_ovf = 1'b1;
      acc = t;
    end
    return acc;
  endfunction

  function automatic logic [31:0] to32(input longint v);
    logic [15:0] s;
    s = v[15:0];
    return {16'h0000, s};
  endfunction

  task automatic push(input logic [15:0] x, output bit acc);
    @(negedge clk);
    bus.sample_i       = x;
    bus.sample_valid_i = 1'b1;
    acc = bus.sample_ready_o;
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    if (acc) q.push_back(x);
  endtask

  task automatic load_coeffs(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    logic [15:0] cs [NT];
    int n;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    @(negedge clk);
    for (int i = 0; i < NT; i++) begin
      bus.coeff_valid_i = 1'b1;
      bus.coeff_i       = cs[i];
      n = 0;
      while (bus.coeff_ready_o !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("coef_ready_wait", 32'(bus.coeff_ready_o), 32'h1);
      @(negedge clk);
      cf[i] = longint'($signed(cs[i]));
    end
    bus.coeff_valid_i = 1'b0;
    chk("coef_loaded", 32'(bus.coeff_loaded_o), 32'h1);
    chk("coef_ready_drop", 32'(bus.coeff_ready_o), 32'h0);
  endtask

  task automatic get_result(input string tag, output logic [15:0] r, output int lat);
    logic [15:0] x;
    lat = 0;
    while (bus.result_valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 32'(bus.result_valid_o), 32'h1);
    r = bus.result_o;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk(tag, 32'(r), to32(model_eval(x)));
    end
    chk({tag, "_ovf"}, 32'(bus.overflow_o), 32'(m_ovf));
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
  endtask

  initial begin
    logic [15:0] r, x, exp0;
    bit a;
    int lat, nacc, last, nres, n;

    rstn = 1'b0;
    bus.sample_i = 16'h0000; bus.sample_valid_i = 1'b0;
    bus.coeff_i = 16'h0000;  bus.coeff_valid_i = 1'b0;
    bus.coeff_reload_i = 1'b0; bus.result_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.result_valid_o), 32'h0);
    chk("rst_empty", 32'(bus.fifo_empty_o), 32'h1);
    chk("rst_full", 32'(bus.fifo_full_o), 32'h0);
    chk("rst_loaded", 32'(bus.coeff_loaded_o), 32'h0);
    chk("rst_ovf", 32'(bus.overflow_o), 32'h0);
    chk("rst_result", 32'(bus.result_o), 32'h0);
    rstn = 1'b1;

    // 0.5x^2 + x + 1
    load_coeffs(16'h0080, 16'h0100, 16'h0100);
    push(16'h0100, a);
    chk("push_acc", 32'(a), 32'h1);
    get_result("p_one", r, lat);
    chk("p_one_val", 32'(r), 32'h0280);
    chk("latency", 32'(lat), 32'(NT));
    push(16'h0000, a);
    get_result("p_zero", r, lat);
    chk("p_zero_val", 32'(r), 32'h0100);
    push(16'hFF00, a);
    get_result("p_mone", r, lat);
    chk("p_mone_val", 32'(r), 32'h0080);
    push(16'h7FFF, a);
    get_result("p_sat", r, lat);
    chk("p_sat_val", 32'(r), 32'h7FFF);
    chk("ovf_set", 32'(bus.overflow_o), 32'h1);
    push(16'h0100, a);
    get_result("p_after", r, lat);
    chk("ovf_sticky", 32'(bus.overflow_o), 32'h1);

    // Reload from IDLE, random coefficients, queued random samples.
    @(negedge clk); bus.coeff_reload_i = 1'b1;
    @(negedge clk); bus.coeff_reload_i = 1'b0;
    load_coeffs(16'($urandom_range(0, 1023)) - 16'd512, 16'($urandom_range(0, 1023)) - 16'd512,
                16'($urandom_range(0, 1023)) - 16'd512);
    for (int i = 0; i < 6; i++) push(16'($urandom_range(0, 1023)) - 16'd512, a);
    for (int i = 0; i < 6; i++) get_result("rnd", r, lat);

    // Back-to-back throughput with result_ready_i held high.
    for (int i = 0; i < 4; i++) push(16'($urandom_range(0, 65535)), a);
    bus.result_ready_i = 1'b1;
    last = -1; nres = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.result_valid_o === 1'b1) begin
        if (q.size() > 0) begin
          x = q.pop_front();
          chk("thr_res", 32'(bus.result_o), to32(model_eval(x)));
        end
        if (last >= 0) chk("thr_gap", 32'(c - last), 32'(NT + 1));
        last = c;
        nres++;
      end
      @(negedge clk);
    end
    bus.result_ready_i = 1'b0;
    chk("thr_count", 32'(nres), 32'd4);

    // Asynchronous reset while computing, with a sample still queued.
    push(16'h0100, a);
    push(16'h0200, a);
    chk("pre_rst_empty", 32'(bus.fifo_empty_o), 32'h0);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.result_valid_o), 32'h0);
    chk("mid_rst_empty", 32'(bus.fifo_empty_o), 32'h1);
    chk("mid_rst_loaded", 32'(bus.coeff_loaded_o), 32'h0);
    chk("mid_rst_ovf", 32'(bus.overflow_o), 32'h0);
    q.delete();
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Fill FIFO without coefficients; the 17th push must be dropped.
    nacc = 0;
    for (int i = 0; i < (2 ** AL) + 1; i++) begin
      push(16'($urandom_range(0, 65535)), a);
      if (a) nacc++;
    end
    chk("fill_count", 32'(nacc), 32'(2 ** AL));
    chk("fill_full", 32'(bus.fifo_full_o), 32'h1);
    chk("fill_ready", 32'(bus.sample_ready_o), 32'h0);
    chk("fill_novalid", 32'(bus.result_valid_o), 32'h0);
    load_coeffs(16'($urandom_range(0, 1023)) - 16'd512, 16'($urandom_range(0, 1023)) - 16'd512,
                16'($urandom_range(0, 1023)) - 16'd512);

    // Stall the first result while topping the FIFO back up to full.
    n = 0;
    while (bus.result_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp0 = 16'(model_eval(q[0]));
    push(16'($urandom_range(0, 65535)), a);
    chk("stall_push", 32'(a), 32'h1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.result_valid_o), 32'h1);
      chk("stall_result", 32'(bus.result_o), 32'(exp0));
    end
    chk("stall_nopop", 32'(bus.fifo_full_o), 32'h1);
    for (int i = 0; i < (2 ** AL) + 1; i++) get_result("fifo_order", r, lat);
    chk("drain_empty", 32'(bus.fifo_empty_o), 32'h1);

    // Reload requested mid-COMPUTE: current result completes first.
    push(16'($urandom_range(0, 1023)) - 16'd512, a);
    @(negedge clk); bus.coeff_reload_i = 1'b1;
    @(negedge clk); bus.coeff_reload_i = 1'b0;
    get_result("reload_res", r, lat);
    n = 0;
    while (bus.coeff_ready_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reload_ready", 32'(bus.coeff_ready_o), 32'h1);
    chk("reload_unloaded", 32'(bus.coeff_loaded_o), 32'h0);
    load_coeffs(16'h0080, 16'h0100, 16'h0100);
    push(16'h0100, a);
    get_result("post_reload", r, lat);
    chk("post_reload_val", 32'(r), 32'h0280);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
